shift_reg_universal: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 30 +++
 rtl/shift_reg_step.sv | 30 +++
 rtl/shift_reg_universal.sv | 98 +++++++++
 tb/tb_shift_reg_universal.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings,
// sequencer states and the shift-mode classifier.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASHR = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Only these modes can be sequenced by START; anything else executes once.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        logic r;
        case (mode)
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASHR: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_reg_step.sv
// Combinational next value of the register for a single step of one mode.
// Serial inputs are taken live so multi-step shifts see them every step.
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sil,
    input  logic             i_sir,
    output logic [WIDTH-1:0] o_q
);

    always_comb begin
        // NOTE: every path assigns o_q (default = hold) so no latch is inferred.
        o_q = i_q;
        case (i_mode)
            MODE_SHR:  o_q = {i_sir, i_q[WIDTH-1:1]};
            MODE_SHL:  o_q = {i_q[WIDTH-2:0], i_sil};
            MODE_LOAD: o_q = i_d;
            MODE_ROR:  o_q = {i_q[0], i_q[WIDTH-1:1]};
            MODE_ROL:  o_q = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            MODE_ASHR: o_q = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            default:   o_q = i_q;
        endcase
    end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register with a START/BUSY/DONE sequencer that applies
// AMT single-bit steps of a latched shift mode, one per enabled cycle.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    input  logic             START,
    input  logic [AMT_W-1:0] AMT,
    output logic [WIDTH-1:0] Q,
    output logic             SOL,
    output logic             SOR,
    output logic             BUSY,
    output logic             DONE
);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [AMT_W-1:0] r_cnt;
    logic [2:0]       r_mode;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [AMT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_mode_nxt;
    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step_q;

    // While running, the latched mode drives the step; otherwise the live MODE does.
    assign w_step_mode = (r_state == ST_RUN) ? r_mode : MODE;

    shift_reg_step #(.WIDTH(WIDTH)) u_step (
        .i_mode (w_step_mode),
        .i_q    (r_q),
        .i_d    (D),
        .i_sil  (SIL),
        .i_sir  (SIR),
        .o_q    (w_step_q)
    );

    // NOTE: reset is sampled on the clock edge and wins over EN and any run in progress.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_HOLD;
        end else if (EN) begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (START && is_shift_mode(MODE)) begin
                    w_mode_nxt  = MODE;
                    w_cnt_nxt   = AMT;
                    w_state_nxt = (AMT == '0) ? ST_FIN : ST_RUN;
                end else begin
                    w_q_nxt     = w_step_q;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_q_nxt     = w_step_q;
                w_cnt_nxt   = r_cnt - AMT_W'(1);
                w_state_nxt = (r_cnt <= AMT_W'(1)) ? ST_FIN : ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (r_state == ST_RUN);
        DONE = (r_state == ST_FIN);
    end

    assign Q   = r_q;
    assign SOL = r_q[WIDTH-1];
    assign SOR = r_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed-vector bench for shift_reg_universal with hand-computed expectations.
module tb_shift_reg_universal;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             CLK = 1'b0;
    logic             RSTn;
    logic             EN;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SIL;
    logic             SIR;
    logic             START;
    logic [AMT_W-1:0] AMT;
    logic [WIDTH-1:0] Q;
    logic             SOL;
    logic             SOR;
    logic             BUSY;
    logic             DONE;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    always #5 CLK = ~CLK;

    shift_reg_universal #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .EN    (EN),
        .MODE  (MODE),
        .D     (D),
        .SIL   (SIL),
        .SIR   (SIR),
        .START (START),
        .AMT   (AMT),
        .Q     (Q),
        .SOL   (SOL),
        .SOR   (SOR),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One rising edge, then settle 1 time unit before sampling or driving.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        MODE = 3'b011; D = val; START = 1'b0; EN = 1'b1;
        step();
        MODE = 3'b000;
    endtask

    // Counts enabled cycles until DONE, bounded so a stuck sequencer still ends.
    task automatic wait_done(output int n);
        n = 0;
        while (!DONE && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        RSTn = 1'b0; EN = 1'b0; MODE = 3'b000; D = '0;
        SIL = 1'b0; SIR = 1'b0; START = 1'b0; AMT = '0;
        step(); step();
        check("rst_q", Q, 8'h00);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        RSTn = 1'b1;

        // LOAD then ROR by 3
        load(8'hB4);
        check("load_b4", Q, 8'hB4);
        MODE = 3'b100; START = 1'b1; AMT = 4'd3;
        step();
        START = 1'b0; MODE = 3'b000;
        check("ror_start_q", Q, 8'hB4);
        check("ror_start_busy", BUSY, 1'b1);
        step();
        check("ror_s1", Q, 8'h5A);
        check("ror_s1_busy", BUSY, 1'b1);
        step();
        check("ror_s2", Q, 8'h2D);
        check("ror_s2_busy", BUSY, 1'b1);
        step();
        check("ror_s3", Q, 8'h96);
        check("ror_s3_busy", BUSY, 1'b0);
        check("ror_done", DONE, 1'b1);
        step();
        check("ror_done_pulse", DONE, 1'b0);
        check("ror_hold", Q, 8'h96);

        // ASHR by 2 from 0x90
        load(8'h90);
        MODE = 3'b110; START = 1'b1; AMT = 4'd2;
        step();
        START = 1'b0;
        step();
        check("ashr_s1", Q, 8'hC8);
        step();
        check("ashr_s2", Q, 8'hE4);
        check("ashr_done", DONE, 1'b1);
        step();
        check("ashr_done_once", DONE, 1'b0);

        // Single-cycle SHL with SIL=1
        load(8'h81);
        check("sol_pre", SOL, 1'b1);
        check("sor_pre", SOR, 1'b1);
        MODE = 3'b010; SIL = 1'b1;
        step();
        check("shl_once", Q, 8'h03);
        check("sol_post", SOL, 1'b0);
        SIL = 1'b0; MODE = 3'b000;

        // SHR by 9 from 0xFF flushes to zero
        load(8'hFF);
        MODE = 3'b001; SIR = 1'b0; START = 1'b1; AMT = 4'd9;
        step();
        START = 1'b0;
        check("shr9_busy0", BUSY, 1'b1);
        step();
        check("shr9_s1", Q, 8'h7F);
        for (int i = 1; i < 9; i++) begin
            step();
            if (i < 8) check("shr9_busy", BUSY, 1'b1);
        end
        check("shr9_q", Q, 8'h00);
        check("shr9_busy_end", BUSY, 1'b0);
        check("shr9_done", DONE, 1'b1);
        MODE = 3'b000;
        step();

        // AMT=0 goes straight to DONE
        load(8'h3C);
        MODE = 3'b101; START = 1'b1; AMT = 4'd0;
        step();
        START = 1'b0; MODE = 3'b000;
        check("amt0_q", Q, 8'h3C);
        check("amt0_busy", BUSY, 1'b0);
        check("amt0_done", DONE, 1'b1);
        step();
        check("amt0_done_end", DONE, 1'b0);

        // ROL by 4 with a 2-cycle stall and ignored START/MODE/D during RUN
        load(8'h01);
        MODE = 3'b101; START = 1'b1; AMT = 4'd4;
        step();
        START = 1'b0;
        step();
        check("rol_s1", Q, 8'h02);
        EN = 1'b0;
        step(); step();
        check("stall_q", Q, 8'h02);
        check("stall_busy", BUSY, 1'b1);
        EN = 1'b1; START = 1'b1; MODE = 3'b011; D = 8'hFF; AMT = 4'd1;
        step();
        check("rol_s2", Q, 8'h04);
        step();
        check("rol_s3", Q, 8'h08);
        step();
        START = 1'b0; MODE = 3'b000;
        check("rol_s4", Q, 8'h10);
        check("rol_done", DONE, 1'b1);
        EN = 1'b0;
        step();
        check("stall_done_held", DONE, 1'b1);
        check("stall_q_fin", Q, 8'h10);
        EN = 1'b1;
        step();
        check("rol_done_end", DONE, 1'b0);

        // Reset mid-run
        load(8'hAA);
        MODE = 3'b010; SIL = 1'b0; START = 1'b1; AMT = 4'd5;
        step();
        START = 1'b0;
        step();
        check("pre_rst_q", Q, 8'h54);
        RSTn = 1'b0;
        step();
        RSTn = 1'b1; MODE = 3'b000;
        check("midrst_q", Q, 8'h00);
        check("midrst_busy", BUSY, 1'b0);
        check("midrst_done", DONE, 1'b0);

        // START with EN=0 is ignored
        load(8'h0F);
        EN = 1'b0; MODE = 3'b001; START = 1'b1; AMT = 4'd3;
        step();
        START = 1'b0; EN = 1'b1; MODE = 3'b000;
        check("start_en0_busy", BUSY, 1'b0);
        check("start_en0_q", Q, 8'h0F);
        step();
        check("start_en0_busy2", BUSY, 1'b0);

        // Reserved and hold modes; START with LOAD acts as a plain load
        load(8'h5A);
        MODE = 3'b111;
        step();
        check("rsvd_hold", Q, 8'h5A);
        MODE = 3'b000;
        step();
        check("mode0_hold", Q, 8'h5A);
        MODE = 3'b011; D = 8'hC3; START = 1'b1; AMT = 4'd3;
        step();
        START = 1'b0; MODE = 3'b000;
        check("start_load_q", Q, 8'hC3);
        check("start_load_busy", BUSY, 1'b0);
        check("start_load_done", DONE, 1'b0);
        MODE = 3'b001; SIR = 1'b1;
        step();
        check("shr_sir1", Q, 8'hE1);
        SIR = 1'b0;

        // Over-width counts: ASHR flushes to sign, ROR wraps modulo WIDTH
        load(8'h80);
        MODE = 3'b110; START = 1'b1; AMT = 4'd9;
        step();
        START = 1'b0;
        wait_done(cyc);
        check("ashr9_cycles", cyc, 9);
        check("ashr9_q", Q, 8'hFF);
        load(8'h01);
        MODE = 3'b100; START = 1'b1; AMT = 4'd9;
        step();
        START = 1'b0;
        wait_done(cyc);
        check("ror9_cycles", cyc, 9);
        check("ror9_q", Q, 8'h80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
